// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and helpers for the bus round-robin arbiter.
package bus_rr_arbiter_pkg;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned MAX_SEL = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  // OR-reduction encoder; only meaningful for one-hot (or zero) input.
  function automatic logic [MAX_SEL-1:0] onehot_to_bin(input logic [MAX_REQ-1:0] oh);
    logic [MAX_SEL-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) b = b | MAX_SEL'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational cyclic priority pick: first unmasked request at or above ptr_i, wrapping.
module rr_priority_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             any_o
);

  logic [N_REQ-1:0] eff_req;
  logic [PTR_W-1:0] idx;
  logic             found;

  assign eff_req = req_i & ~mask_i;
  assign any_o   = |eff_req;

  // N_REQ is a power of two, so PTR_W-bit addition wraps the search naturally.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr_i + PTR_W'(i);
      if (!found && eff_req[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter driving a shared mux select; grant held until release.
// Optional tenure watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned SEL_WIDTH = 2,
  parameter int unsigned MAX_HOLD  = 16,
  localparam int unsigned N_REQ    = 1 << SEL_WIDTH
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic [N_REQ-1:0]     I_req,
  input  logic                 I_done,
  output logic [N_REQ-1:0]     o_grant,
  output logic [SEL_WIDTH-1:0] o_sel,
  output logic                 o_valid,
  output logic                 o_timeout,
  output arb_state_e           o_state
);

  arb_state_e           state_q;
  logic [N_REQ-1:0]     grant_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [SEL_WIDTH-1:0] ptr_q;

  logic                 release_now;
  logic                 force_rel;
  logic [SEL_WIDTH-1:0] pick_ptr;
  logic [N_REQ-1:0]     pick_mask;
  logic [N_REQ-1:0]     pick_win;
  logic                 pick_any;
  logic [SEL_WIDTH-1:0] pick_sel;

  // On release the search restarts just past the owner and the owner is masked,
  // so handover happens in the same edge and the owner drops to lowest priority.
  assign release_now = (state_q == GRANT) && (I_done || !I_req[sel_q] || force_rel);
  assign pick_ptr    = release_now ? sel_q + SEL_WIDTH'(1) : ptr_q;
  assign pick_mask   = release_now ? grant_q : '0;
  assign pick_sel    = SEL_WIDTH'(onehot_to_bin(MAX_REQ'(pick_win)));

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (SEL_WIDTH)
  ) u_pick (
    .req_i    (I_req),
    .ptr_i    (pick_ptr),
    .mask_i   (pick_mask),
    .winner_o (pick_win),
    .any_o    (pick_any)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q <= GRANT;
            grant_q <= pick_win;
            sel_q   <= pick_sel;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_q <= pick_ptr;
            if (pick_any) begin
              grant_q <= pick_win;
              sel_q   <= pick_sel;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);

  logic [CNT_W-1:0] hold_cnt_q;
  logic             timeout_q;

  assign force_rel = (state_q == GRANT) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  // Counter is zero whenever a tenure starts: it clears on every release and in IDLE.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if ((state_q == GRANT) && !release_now) hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      else                                    hold_cnt_q <= '0;
    end
  end

  assign o_timeout = timeout_q;
`else
  // No watchdog: a tenure ends only on I_done or a dropped request.
  assign force_rel = 1'b0 & (MAX_HOLD < 2);
  assign o_timeout = 1'b0;
`endif

  assign o_grant = grant_q;
  assign o_sel   = sel_q;
  assign o_valid = (state_q == GRANT);
  assign o_state = state_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (SEL_WIDTH = 2, MAX_HOLD = 4) and rr_priority_pick.
module tb_bus_rr_arbiter;
  import bus_rr_arbiter_pkg::*;

  localparam int unsigned SEL_W = 2;
  localparam int unsigned N     = 4;

  // clock / reset
  logic I_clk   = 1'b0;
  logic I_rst_n = 1'b0;
  always #5 I_clk = ~I_clk;

  logic [N-1:0]     I_req  = '0;
  logic             I_done = 1'b0;
  logic [N-1:0]     o_grant;
  logic [SEL_W-1:0] o_sel;
  logic             o_valid;
  logic             o_timeout;
  arb_state_e       o_state;

  bus_rr_arbiter #(
    .SEL_WIDTH (SEL_W),
    .MAX_HOLD  (4)
  ) dut (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_req     (I_req),
    .I_done    (I_done),
    .o_grant   (o_grant),
    .o_sel     (o_sel),
    .o_valid   (o_valid),
    .o_timeout (o_timeout),
    .o_state   (o_state)
  );

  logic [N-1:0] pk_req  = '0;
  logic [1:0]   pk_ptr  = '0;
  logic [N-1:0] pk_mask = '0;
  logic [N-1:0] pk_win;
  logic         pk_any;

  rr_priority_pick #(.N_REQ(N), .PTR_W(2)) u_pick (
    .req_i    (pk_req),
    .ptr_i    (pk_ptr),
    .mask_i   (pk_mask),
    .winner_o (pk_win),
    .any_o    (pk_any)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [N-1:0] g,
                             input logic [SEL_W-1:0] s, input logic v);
    check_eq({tag, ".grant"}, 32'(o_grant), 32'(g));
    check_eq({tag, ".sel"},   32'(o_sel),   32'(s));
    check_eq({tag, ".valid"}, 32'(o_valid), 32'(v));
  endtask

  task automatic reset_dut();
    I_rst_n = 1'b0;
    I_req   = '0;
    I_done  = 1'b0;
    tick();
    tick();
    I_rst_n = 1'b1;
  endtask

  // pick vectors: req, ptr, mask -> winner, any
  logic [N-1:0] pv_req  [6] = '{4'b1111, 4'b1010, 4'b0011, 4'b0110, 4'b0000, 4'b0001};
  logic [1:0]   pv_ptr  [6] = '{2'd0,    2'd2,    2'd3,    2'd1,    2'd2,    2'd0};
  logic [N-1:0] pv_mask [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
  logic [N-1:0] pv_win  [6] = '{4'b0001, 4'b1000, 4'b0001, 4'b0100, 4'b0000, 4'b0000};
  logic         pv_any  [6] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0};

  logic [N-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // standalone pick
    for (int i = 0; i < 6; i++) begin
      pk_req  = pv_req[i];
      pk_ptr  = pv_ptr[i];
      pk_mask = pv_mask[i];
      #1;
      check_eq($sformatf("pick%0d.win", i), 32'(pk_win), 32'(pv_win[i]));
      check_eq($sformatf("pick%0d.any", i), 32'(pk_any), 32'(pv_any[i]));
    end

    // reset state with a request already pending
    I_req = 4'b0100;
    tick();
    tick();
    check_grant("rst", 4'b0000, 2'd0, 1'b0);
    check_eq("rst.timeout", 32'(o_timeout), 32'd0);
    check_eq("rst.state", 32'(o_state), 32'(IDLE));
    I_rst_n = 1'b1;
    tick();
    check_grant("first", 4'b0100, 2'd2, 1'b1);
    check_eq("first.state", 32'(o_state), 32'(GRANT));

    // full rotation with zero-bubble handover
    reset_dut();
    I_req = 4'b1111;
    tick();
    check_grant("rr0", rr_seq[0], 2'd0, 1'b1);
    I_done = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check_grant($sformatf("rr%0d", i), rr_seq[i], SEL_W'(i % 4), 1'b1);
    end
    I_done = 1'b0;

`ifndef ARB_TIMEOUT_EN
    // long tenure is not pre-empted, then hands over on I_done
    reset_dut();
    I_req = 4'b0010;
    tick();
    I_req = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq($sformatf("hold%0d.grant", i), 32'(o_grant), 32'(4'b0010));
    end
    check_eq("hold.timeout", 32'(o_timeout), 32'd0);
    I_done = 1'b1;
    tick();
    I_done = 1'b0;
    check_grant("handover", 4'b1000, 2'd3, 1'b1);
`endif

    // owner drops with nothing else pending: idle, sel kept
    reset_dut();
    I_req = 4'b0100;
    tick();
    check_grant("own2", 4'b0100, 2'd2, 1'b1);
    I_req = 4'b0000;
    tick();
    check_grant("drop", 4'b0000, 2'd2, 1'b0);
    check_eq("drop.state", 32'(o_state), 32'(IDLE));
    I_done = 1'b1;
    tick();
    check_grant("idle_done", 4'b0000, 2'd2, 1'b0);
    I_done = 1'b0;
    I_req  = 4'b0001;
    tick();
    check_grant("wrap0", 4'b0001, 2'd0, 1'b1);

    // releasing owner is masked for one edge, then regains
    reset_dut();
    I_req = 4'b0100;
    tick();
    I_done = 1'b1;
    tick();
    I_done = 1'b0;
    check_grant("selfmask", 4'b0000, 2'd2, 1'b0);
    tick();
    check_grant("regain", 4'b0100, 2'd2, 1'b1);

    // async reset mid-tenure
    reset_dut();
    I_req = 4'b1000;
    tick();
    check_grant("own3", 4'b1000, 2'd3, 1'b1);
    #2;
    I_rst_n = 1'b0;
    #1;
    check_grant("async_rst", 4'b0000, 2'd0, 1'b0);
    tick();
    I_rst_n = 1'b1;
    I_req   = 4'b1001;
    tick();
    check_grant("post_rst", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // watchdog forces handover after MAX_HOLD grant cycles
    reset_dut();
    I_req = 4'b0011;
    tick();
    check_grant("wd_start", 4'b0001, 2'd0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq($sformatf("wd_hold%0d.grant", i), 32'(o_grant), 32'(4'b0001));
      check_eq($sformatf("wd_hold%0d.timeout", i), 32'(o_timeout), 32'd0);
    end
    tick();
    check_grant("wd_force", 4'b0010, 2'd1, 1'b1);
    check_eq("wd_force.timeout", 32'(o_timeout), 32'd1);
    tick();
    check_eq("wd_after.timeout", 32'(o_timeout), 32'd0);
    check_eq("wd_after.grant", 32'(o_grant), 32'(4'b0010));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource (a bus driven through a BLOCK_MUX-style select tree) between N = 2^SEL_WIDTH requesters.
- Grants one requester at a time, holds the grant until that requester releases, and drives the binary mux select.
- Sits between requesting units (register file ports, ALU operand sources) and the shared mux tree.

Parameters:
- SEL_WIDTH, 2, width of the mux select; number of requesters N = 1 << SEL_WIDTH.
- N_REQ, 1 << SEL_WIDTH, number of requesters; derived, not overridden independently.
- MAX_HOLD, 16, watchdog limit in cycles; used only with ARB_TIMEOUT_EN; must be >= 2.

Ports:
- I_clk  input  1  clock; all state updates on the rising edge.
- I_rst_n  input  1  asynchronous active-low reset.
- I_req  input  N_REQ  request vector; bit k set means requester k wants the resource.
- I_done  input  1  release strobe from the current grant holder; sampled only in GRANT.
- o_grant  output  N_REQ  one-hot grant, registered; all zero when idle.
- o_sel  output  SEL_WIDTH  binary index of the granted requester; connects to the mux I_sel.
- o_valid  output  1  high when o_grant is nonzero.
- o_timeout  output  1  one-cycle pulse on forced release; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async assert, sync release):
  - o_grant = 0, o_sel = 0, o_valid = 0, o_timeout = 0.
  - State = IDLE; priority pointer ptr = 0.
- States:
  - IDLE: no grant.
  - GRANT: o_grant is one-hot, held stable.
- Priority pick (combinational): the first set bit of I_req, searching cyclically from index ptr upward, wrapping N_REQ-1 to 0.
- IDLE -> GRANT: when I_req is nonzero at a clock edge, register the winner into o_grant/o_sel/o_valid. One cycle of latency from request to grant.
- GRANT holds while I_req[owner] = 1 and I_done = 0. o_sel is unchanged for the whole tenure.
- Release happens when I_done = 1, or when I_req[owner] drops to 0, at a clock edge. On release:
  - ptr <= (owner + 1) mod N_REQ.
  - If I_req has any bit set other than the owner's, grant the next winner in the same edge. The pick uses the updated ptr, so handover has zero bubble and o_valid stays 1.
  - Otherwise go to IDLE; o_grant = 0, o_valid = 0, and o_sel keeps its last value.
- The releasing owner's own request is masked for that edge only. It can regain the grant one cycle later, at lowest priority.
- Simultaneous requests from IDLE: the lowest index at or above ptr wins. After reset, with I_req = 4'b1111, requester 0 wins.
- I_done in IDLE is ignored.
- Requests arriving while another requester holds the grant do not pre-empt it.
- Fairness: under continuous requests, each requester waits at most N_REQ-1 tenures.
- o_grant must never have more than one bit set. o_sel == index(o_grant) whenever o_valid = 1.
- Reset asserted mid-GRANT: outputs clear immediately (asynchronous); ptr returns to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A tenure counter clears on each new grant and increments every GRANT cycle.
  - When the count reaches MAX_HOLD-1 without a release, force a release at the next edge, exactly as if I_done were asserted.
  - o_timeout pulses high for one cycle, coincident with the new grant or idle state.
- Undefined: no counter logic exists; o_timeout is tied 0; a tenure can last indefinitely.

Decomposition:
- Shared package: state encoding (IDLE = 0, GRANT = 1), a clog2 helper, and a one-hot-to-binary function reused by o_sel.
- One sub-module: rr_priority_pick. It is combinational, takes req, ptr and mask, and returns a one-hot winner plus an any-valid flag. The bench verifies it standalone.

Test Plan (SEL_WIDTH = 2):
- Reset with I_req = 4'b0100 held -> first edge after release: o_grant = 4'b0100, o_sel = 2, o_valid = 1.
- After reset, I_req = 4'b1111 with I_done pulsed each tenure -> grant sequence 0,1,2,3,0; o_valid continuously 1 with no bubble.
- Owner 1 holds, I_req = 4'b1010, I_done = 0 for 10 cycles -> o_grant stays 4'b0010; I_done = 1 -> next edge o_grant = 4'b1000.
- Owner 2 drops I_req[2] with no other requests -> next edge o_grant = 0, o_valid = 0, o_sel stays 2; then I_req = 4'b0001 -> o_sel = 0.
- Reset asserted mid-GRANT (owner 3) -> o_grant = 0 immediately, without waiting for an edge; after release, I_req = 4'b1001 -> requester 0 wins.
- With ARB_TIMEOUT_EN and MAX_HOLD = 4: owner 0 holds with I_done = 0 and I_req = 4'b0011 -> forced handover to requester 1 after 4 GRANT cycles, with a one-cycle o_timeout pulse.
